// File: rtl/background_pkg.sv
// Shared types and constants for the scrolling background renderer.
package background_pkg;

  localparam int BG_TILE_COLS = 32;
  localparam int BG_TILE_ROWS = 30;
  localparam int BG_PATTERNS  = 32;
  localparam int BG_PALETTES  = 2;
  localparam int BG_ADDR_W    = 12;

  localparam int PMB_BASE      = 'h000;
  localparam int NTBL_BASE     = 'h400;
  localparam int PAL_BASE      = 'h7C0;
  localparam int SCROLL_X_ADDR = 'h7E0;
  localparam int SCROLL_Y_ADDR = 'h7E1;

  typedef struct packed {
    logic       palsel;
    logic       hflip;
    logic       vflip;
    logic [4:0] pattern;
  } tile_entry_t;

  typedef struct packed {
    logic [2:0]  color;
    logic [15:0] line;
  } bsm_entry_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CALC,
    ST_NT,
    ST_PAT,
    ST_DONE
  } fetch_state_t;

endpackage

// File: rtl/bg_linebuf_m.sv
// Ping-pong line buffer: one bank is displayed while the other is filled.
module bg_linebuf_m
  import background_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int IDX_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             swap,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  bsm_entry_t       wr_data,
  input  logic [IDX_W-1:0] rd_idx,
  output bsm_entry_t       rd_data
);

  bsm_entry_t bank0 [DEPTH];
  bsm_entry_t bank1 [DEPTH];
  logic       sel;   // selects the front (displayed) bank

  // Front/back selector flips on every swap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    sel <= 1'b0;
    else if (swap) sel <= ~sel;
  end

  // Writes always land in the back bank.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (sel) bank0[wr_idx] <= wr_data;
      else     bank1[wr_idx] <= wr_data;
    end
  end

  // Combinational read of the front bank.
  always_comb rd_data = sel ? bank1[rd_idx] : bank0[rd_idx];

endmodule

// File: rtl/pattern_hflipper_m.sv
// Mirrors an 8-pixel, 2bpp pattern line horizontally when hflip is set.
module pattern_hflipper_m (
  input  logic [15:0] line_in,
  input  logic        hflip,
  output logic [15:0] line_out
);

  // Swap 2-bit pixel slots end for end.
  always_comb begin
    line_out = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (hflip) line_out[2*i +: 2] = line_in[2*(7-i) +: 2];
      else       line_out[2*i +: 2] = line_in[2*i +: 2];
    end
  end

endmodule

// File: rtl/background_scroll_m.sv
// Tile background renderer: prefetches the next scanline into a line buffer
// and streams scrolled pixels out of the previously fetched line.
module background_scroll_m
  import background_pkg::*;
#(
  parameter int TILE_COLS = BG_TILE_COLS,
  parameter int TILE_ROWS = BG_TILE_ROWS,
  parameter int PATTERNS  = BG_PATTERNS,
  parameter int PALETTES  = BG_PALETTES,
  parameter int ADDR_W    = BG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        xp,
  input  logic              visible,
  input  logic              line_start,
  input  logic [7:0]        fetch_y,
  input  logic              writable,
  input  logic              we,
  input  logic [ADDR_W-1:0] address,
  input  logic [7:0]        data,
  output logic [1:0]        r,
  output logic [1:0]        g,
  output logic [1:0]        b,
  output logic              busy,
  output logic              underrun
);

  localparam int COL_W  = $clog2(TILE_COLS);
  localparam int XS_W   = COL_W + 3;
  localparam int PAL_W  = (PALETTES > 1) ? $clog2(PALETTES) : 1;
  localparam int VLINES = TILE_ROWS * 8;

  localparam logic [ADDR_W-1:0] PMB_HI = ADDR_W'(PMB_BASE + PATTERNS * 16);
  localparam logic [ADDR_W-1:0] NT_LO  = ADDR_W'(NTBL_BASE);
  localparam logic [ADDR_W-1:0] NT_HI  = ADDR_W'(NTBL_BASE + TILE_ROWS * 32);
  localparam logic [ADDR_W-1:0] PAL_LO = ADDR_W'(PAL_BASE);
  localparam logic [ADDR_W-1:0] PAL_HI = ADDR_W'(PAL_BASE + PALETTES);
  localparam logic [ADDR_W-1:0] SX_A   = ADDR_W'(SCROLL_X_ADDR);
  localparam logic [ADDR_W-1:0] SY_A   = ADDR_W'(SCROLL_Y_ADDR);
  localparam logic [COL_W-1:0]  COL_LAST = COL_W'(TILE_COLS - 1);

  logic [7:0] pmb  [512];
  logic [7:0] ntbl [1024];
  logic [2:0] palette [PALETTES];

  logic [7:0] scroll_x, scroll_y, sx_sh, sy_sh, fetch_y_q, vy, vy_calc;
  logic [8:0] vsum, xsum;
  logic [COL_W-1:0] col;
  logic       front_valid;
  logic       hit_pmb, hit_nt, hit_pal, hit_sx, hit_sy;
  tile_entry_t tile_q;
  logic [2:0]  ty_eff;
  logic [15:0] line_flipped;
  logic [PAL_W-1:0] pal_idx;
  logic [XS_W-1:0]  xs;
  logic [1:0]  pixel;
  bsm_entry_t  wr_entry, rd_entry;
  fetch_state_t state, state_next;

  // Write address decode; palette/scroll take priority over the unused NTBL rows.
  always_comb begin
    hit_pmb = 1'b0;
    hit_nt  = 1'b0;
    hit_pal = 1'b0;
    hit_sx  = 1'b0;
    hit_sy  = 1'b0;
    if (we && writable) begin
      hit_pmb = (address < PMB_HI);
      hit_nt  = (address >= NT_LO) && (address < NT_HI);
      hit_pal = (address >= PAL_LO) && (address < PAL_HI);
      hit_sx  = (address == SX_A);
      hit_sy  = (address == SY_A);
    end
  end

  // Pattern and nametable memories (not reset; reads are asynchronous).
  always_ff @(posedge clk) begin
    if (hit_pmb) pmb[address[8:0]]  <= data;
    if (hit_nt)  ntbl[address[9:0]] <= data;
  end

  // Palette and live scroll registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scroll_x <= '0;
      scroll_y <= '0;
      for (int unsigned i = 0; i < PALETTES; i++) palette[i] <= '0;
    end else begin
      if (hit_sx)  scroll_x <= data;
      if (hit_sy)  scroll_y <= data;
      if (hit_pal) palette[address[PAL_W-1:0]] <= data[2:0];
    end
  end

  // Fetch FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_next;
  end

  // Next state; line_start restarts the fetch from any state (abort included).
  always_comb begin
    state_next = state;
    if (line_start) begin
      state_next = ST_CALC;
    end else begin
      unique case (state)
        ST_IDLE: state_next = ST_IDLE;
        ST_CALC: state_next = ST_NT;
        ST_NT:   state_next = ST_PAT;
        ST_PAT:  state_next = (col == COL_LAST) ? ST_DONE : ST_NT;
        ST_DONE: state_next = ST_DONE;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  assign busy = (state == ST_CALC) || (state == ST_NT) || (state == ST_PAT);

  // Vertical wrap: a single conditional subtract is enough for on-screen inputs.
  always_comb begin
    vsum    = {1'b0, fetch_y_q} + {1'b0, sy_sh};
    vy_calc = (vsum >= 9'(VLINES)) ? 8'(vsum - 9'(VLINES)) : vsum[7:0];
  end

  // Fetch datapath, shadow latches and sticky underrun.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col         <= '0;
      vy          <= '0;
      tile_q      <= '0;
      fetch_y_q   <= '0;
      sx_sh       <= '0;
      sy_sh       <= '0;
      front_valid <= 1'b0;
      underrun    <= 1'b0;
    end else if (line_start) begin
      fetch_y_q   <= fetch_y;
      sx_sh       <= scroll_x;
      sy_sh       <= scroll_y;
      front_valid <= (state == ST_DONE);
      if (busy) underrun <= 1'b1;
      col         <= '0;
    end else begin
      unique case (state)
        ST_CALC: vy <= vy_calc;
        ST_NT:   tile_q <= ntbl[{vy[7:3], 5'(col)}];
        ST_PAT:  if (col != COL_LAST) col <= col + 1'b1;
        default: ;
      endcase
    end
  end

  // Pattern row lookup with vertical flip and palette resolution for the entry.
  always_comb begin
    ty_eff   = tile_q.vflip ? ~vy[2:0] : vy[2:0];
    pal_idx  = (PALETTES > 1) ? PAL_W'(tile_q.palsel) : '0;
    wr_entry = '{color: palette[pal_idx], line: line_flipped};
  end

  pattern_hflipper_m u_hflip (
    .line_in  ({pmb[{tile_q.pattern, ty_eff, 1'b0}], pmb[{tile_q.pattern, ty_eff, 1'b1}]}),
    .hflip    (tile_q.hflip),
    .line_out (line_flipped)
  );

  bg_linebuf_m #(
    .DEPTH (TILE_COLS),
    .IDX_W (COL_W)
  ) u_linebuf (
    .clk     (clk),
    .rst_n   (rst),
    .swap    (line_start),
    .wr_en   ((state == ST_PAT) && !line_start),
    .wr_idx  (col),
    .wr_data (wr_entry),
    .rd_idx  (xs[XS_W-1:3]),
    .rd_data (rd_entry)
  );

  // Horizontal scroll wraps at the line width by truncation.
  always_comb begin
    xsum  = {1'b0, xp} + {1'b0, sx_sh};
    xs    = xsum[XS_W-1:0];
    pixel = rd_entry.line[{~xs[2:0], 1'b0} +: 2];
  end

  // Registered colour output, blanked outside video or without a valid line.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r <= '0;
      g <= '0;
      b <= '0;
    end else if (visible && front_valid) begin
      r <= pixel & {2{rd_entry.color[2]}};
      g <= pixel & {2{rd_entry.color[1]}};
      b <= pixel & {2{rd_entry.color[0]}};
    end else begin
      r <= '0;
      g <= '0;
      b <= '0;
    end
  end

endmodule

// File: doc/background_scroll_m.md
Name: background_scroll_m

Overview:
- Parametrised next-generation background renderer with per-scanline prefetch.
- During the previous scanline, a fetch FSM reads nametable entries and pattern rows into a ping-pong line buffer.
- Pixels stream out from the front buffer with per-line shadowed X/Y scroll.
- Sits between the VRAM write bus and the GPU pixel mixer, alongside the sprite unit.

Parameters:
- TILE_COLS, 32, nametable columns (power of 2); line width = TILE_COLS*8 px
- TILE_ROWS, 30, visible nametable rows; vertical wrap at TILE_ROWS*8 lines
- PATTERNS, 32, background patterns (8x8, 2bpp, 16 bytes each)
- PALETTES, 2, selectable tile colours (3-bit RGB enable masks)
- ADDR_W, 12, VRAM address width

Ports:
- clk, in, 1, pixel clock (12.5875 MHz)
- rst, in, 1, asynchronous active-low reset
- xp, in, 8, current pixel x
- visible, in, 1, active video
- line_start, in, 1, one-cycle pulse, at least 2*TILE_COLS+4 cycles before first visible pixel
- fetch_y, in, 8, screen line to prefetch, sampled on line_start
- writable, in, 1, VRAM write window open
- we, in, 1, VRAM write strobe
- address, in, ADDR_W, VRAM write address
- data, in, 8, VRAM write data
- r, g, b, out, 2 each, registered pixel colour
- busy, out, 1, fetch in progress
- underrun, out, 1, sticky; fetch did not finish before line_start

Behaviour:
- Reset (rst=0, async):
  - r/g/b=0, busy=0, underrun=0, front_valid=0, scroll_x=scroll_y=0, shadows=0, FSM=IDLE.
  - PMB/NTBL contents are not reset.
- Address map:
  - 0x000..PATTERNS*16-1: PMB.
  - 0x400+{row[4:0],col[4:0]}: NTBL tile byte.
  - 0x7C0+i (i<PALETTES): palette i, bits[2:0].
  - 0x7E0: scroll_x; 0x7E1: scroll_y.
  - Any other address: ignored.
- Writes:
  - Take effect on the clk edge when we & writable.
  - we & !writable: write dropped, no state change.
  - Memories are dual-port. A fetch read of a location written in the same cycle returns the old data.
- Tile byte layout: [7] palette select (index = bit mod PALETTES), [6] hflip, [5] vflip, [4:0] pattern index.
- line_start:
  - Swap buffers; front_valid <= (FSM was DONE).
  - If FSM was not IDLE/DONE: underrun <= 1 and the in-progress fetch is aborted.
  - Shadow scroll_x/scroll_y latched.
  - Fetch begins for fetch_y.
- Fetch row: vy = (fetch_y + scroll_y_shadow) mod (TILE_ROWS*8), computed with 9-bit add and one conditional subtract. tile_row = vy[7:3]; ty = vy[2:0].
- FSM states: IDLE -> CALC (1 cycle, vy) -> NT (read tile byte, col c) -> PAT (read 2 PMB bytes, apply vflip/hflip, write back-buffer entry c) -> NT while c<TILE_COLS-1, else DONE.
  - DONE -> CALC on line_start.
  - Fetch takes 2*TILE_COLS+1 cycles; busy=1 in CALC/NT/PAT.
- Back-buffer entry: 16-bit pattern line plus 3-bit colour resolved from the palette at PAT time.
- Output:
  - xs = (xp + scroll_x_shadow) mod (TILE_COLS*8); pixel = entry[xs[7:3]] bits {7-xs[2:0],0}+:2.
  - r/g/b = pixel AND colour bit {2,1,0}, registered: 1-cycle latency from xp.
  - Zero when !visible or !front_valid.
- Mid-line scroll writes affect only the next line_start.
- Reset mid-fetch: immediate return to IDLE; the next line displays black.

Decomposition:
- Package background_pkg:
  - TILE_COLS/TILE_ROWS/PATTERNS/PALETTES defaults.
  - Address-map base constants (PMB_BASE, NTBL_BASE, PAL_BASE, SCROLL_X_ADDR, SCROLL_Y_ADDR).
  - Packed typedef tile_entry_t {palsel, hflip, vflip, pattern[4:0]}.
  - Typedef bsm_entry_t {color[2:0], line[15:0]}.
  - FSM state enum.
- Existing pattern_hflipper_m is reused for the flip.
- One new sub-module, bg_linebuf_m: ping-pong buffer of TILE_COLS bsm_entry_t with swap, write port, and combinational read port.

Test Plan:
- Reset, then write pattern 0 row 0 = 0x1234, tile(0,0)=0x00, palette0=3'b011, writable=1; line_start with fetch_y=0, run 66 cycles, second line_start, sweep xp=0..7 -> pixels 00,01,00,10,00,11,01,00 with r=0, g=b=pixel, each one cycle after xp.
- Set tile(0,0)=0x40 (hflip), repeat -> pixel sequence reversed. Set 0x20 (vflip) with fetch_y=7 -> row 0 data shown.
- scroll_x=5, scroll_y=235, fetch_y=10 -> vy=5 (wraps at 240), column index = (xp+5)>>3. A scroll write after line_start does not change the current line.
- Assert line_start 20 cycles after the previous one -> underrun=1, busy restarts, next line black. Underrun stays 1 until reset.
- Write tile byte with writable=0 -> NTBL unchanged. Write to 0x7E5 -> no effect.
- Deassert rst mid-fetch (busy=1) -> r/g/b=0 and busy=0 immediately, without a clock edge.
